// File: rtl/arm_mem_pkg.sv
// Shared constants for the ARM32 MEM-stage data memory: FSM state encoding,
// lane-count helper and the wait-state upper bound.
package arm_mem_pkg;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int WAIT_MAX = 15;

    function automatic int mem_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/arm_data_mem_bank.sv
// DEPTH x DATA_W word array with per-byte-lane write enables and a registered,
// reset-cleared read port that only updates on a read enable.
module mem_bank
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [mem_lanes(DATA_W)-1:0]  wr_en_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          rd_en_i,
    input  logic [ADDR_W-1:0]             rd_addr_i,
    output logic [DATA_W-1:0]             rd_data_o
);

    localparam int LANES = mem_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en_i[i]) begin
                mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    // Read sees pre-edge contents, so a same-edge write to the same word is not forwarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/arm_data_mem.sv
// MEM-stage data memory: post-reset zeroing sweep, optional wait states with a
// stall handshake, byte-lane writes and an out-of-range address flag.
module arm_data_mem
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          MemReqM,
    input  logic                          MemWriteM,
    input  logic [mem_lanes(DATA_W)-1:0]  ByteEnM,
    input  logic [31:0]                   ALUOutM,
    input  logic [DATA_W-1:0]             WriteDataM,
    output logic [DATA_W-1:0]             ReadDataW,
    output logic                          RdValidW,
    output logic                          StallM,
    output logic                          AddrErrM,
    output logic                          BusyInit
);

    localparam int         LANES     = mem_lanes(DATA_W);
    localparam logic       HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              rd_valid_q;
    logic              exec;
    logic [ADDR_W-1:0] word_idx;
    logic              addr_lsb_unused;

    logic [LANES-1:0]  bank_wr_en;
    logic [ADDR_W-1:0] bank_wr_addr;
    logic [DATA_W-1:0] bank_wr_data;
    logic              bank_rd_en;

    assign word_idx        = ALUOutM[ADDR_W+1:2];
    assign addr_lsb_unused = ^ALUOutM[1:0];

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        wcnt_d     = wcnt_q;
        exec       = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (MemReqM) begin
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        exec = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A request withdrawn mid-wait breaks the pipeline contract; abandon it silently.
                if (!MemReqM) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    exec    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            wcnt_q     <= 4'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            wcnt_q     <= wcnt_d;
            rd_valid_q <= exec & ~MemWriteM;
        end
    end

    // The sweep owns the write port in INIT; reset blocks any commit on its own edge.
    always_comb begin
        bank_wr_en   = '0;
        bank_wr_addr = word_idx;
        bank_wr_data = WriteDataM;
        if (state_q == ST_INIT) begin
            bank_wr_en   = '1;
            bank_wr_addr = init_ptr_q;
            bank_wr_data = '0;
        end else if (exec && MemWriteM) begin
            bank_wr_en = ByteEnM;
        end
        if (reset) begin
            bank_wr_en = '0;
        end
    end

    assign bank_rd_en = exec & ~MemWriteM & ~reset;

    mem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .wr_en_i   (bank_wr_en),
        .wr_addr_i (bank_wr_addr),
        .wr_data_i (bank_wr_data),
        .rd_en_i   (bank_rd_en),
        .rd_addr_i (word_idx),
        .rd_data_o (ReadDataW)
    );

    assign RdValidW = rd_valid_q;
    assign BusyInit = (state_q == ST_INIT);
    assign StallM   = (state_q == ST_INIT)
                    | ((state_q == ST_IDLE) & MemReqM & HAS_WAIT)
                    | ((state_q == ST_WAIT) & (wcnt_q != 4'd0));
    assign AddrErrM = MemReqM & (|ALUOutM[31:ADDR_W+2]);

endmodule

// File: tb/tb_arm_data_mem.sv
// Self-checking bench for arm_data_mem: one instance with no wait states and one
// with three, both checked against a word-array reference model.
module tb_arm_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [2];
    logic        req   [2];
    logic        wr    [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        rdv   [2];
    logic        stall [2];
    logic        aerr  [2];
    logic        busy  [2];

    logic [31:0] model [2][64];
    int n_tests = 0;
    int n_fail  = 0;

    arm_data_mem #(.ADDR_W(6), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .CLOCK_50(clk), .reset(rst[0]), .MemReqM(req[0]), .MemWriteM(wr[0]),
        .ByteEnM(be[0]), .ALUOutM(addr[0]), .WriteDataM(wdata[0]),
        .ReadDataW(rdata[0]), .RdValidW(rdv[0]), .StallM(stall[0]),
        .AddrErrM(aerr[0]), .BusyInit(busy[0])
    );

    arm_data_mem #(.ADDR_W(6), .DATA_W(32), .WAIT_STATES(3)) dut3 (
        .CLOCK_50(clk), .reset(rst[1]), .MemReqM(req[1]), .MemWriteM(wr[1]),
        .ByteEnM(be[1]), .ALUOutM(addr[1]), .WriteDataM(wdata[1]),
        .ReadDataW(rdata[1]), .RdValidW(rdv[1]), .StallM(stall[1]),
        .AddrErrM(aerr[1]), .BusyInit(busy[1])
    );

    function automatic int wait_states(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Counts sweep cycles after reset release; returns at posedge+1 with the DUT idle.
    task automatic wait_init(input int k);
        int nb = 0;
        int ns = 0;
        @(negedge clk);
        while (busy[k] && nb < 200) begin
            nb++;
            if (stall[k]) ns++;
            @(negedge clk);
        end
        chk("init_busy_cycles", nb, 64);
        chk("init_stall_cycles", ns, 64);
        chk("init_busy_clear", {31'b0, busy[k]}, 32'd0);
        chk("init_stall_clear", {31'b0, stall[k]}, 32'd0);
        for (int i = 0; i < 64; i++) model[k][i] = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        req[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata[k], 32'h0);
        chk("reset_rdvalid", {31'b0, rdv[k]}, 32'd0);
        rst[k] = 1'b0;
        wait_init(k);
    endtask

    // Entered and left at posedge+1; a following call is a back-to-back request.
    task automatic access(input int k, input bit w, input logic [31:0] a,
                          input logic [3:0] lanes, input logic [31:0] d);
        int ns = 0;
        int idx;
        logic [31:0] exp_rd;
        idx = int'(a[7:2]);
        exp_rd = model[k][idx];
        req[k] = 1'b1; wr[k] = w; addr[k] = a; be[k] = lanes; wdata[k] = d;
        @(negedge clk);
        chk("addr_err", {31'b0, aerr[k]}, {31'b0, (a[31:8] != 24'h0)});
        while (stall[k] && ns < 40) begin
            ns++;
            @(negedge clk);
        end
        chk("stall_cycles", ns, wait_states(k));
        @(posedge clk); #1;
        req[k] = 1'b0;
        if (w) begin
            chk("wr_rdvalid", {31'b0, rdv[k]}, 32'd0);
            for (int i = 0; i < 4; i++)
                if (lanes[i]) model[k][idx][8*i +: 8] = d[8*i +: 8];
        end else begin
            chk("rd_rdvalid", {31'b0, rdv[k]}, 32'd1);
            chk("rd_data", rdata[k], exp_rd);
        end
    endtask

    task automatic random_ops(input int k, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            if (($urandom & 3) != 0) a[31:8] = 24'h0;
            access(k, bit'($urandom & 1), a, 4'($urandom), $urandom);
        end
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; wr[k] = 1'b0; be[k] = 4'h0;
            addr[k] = 32'h0; wdata[k] = 32'h0;
        end

        // Zero-wait instance: sweep, directed cases, then random traffic.
        do_reset(0);
        for (int i = 0; i < 64; i++) begin
            access(0, 1'b0, 32'(i * 4), 4'h0, 32'h0);
            chk("init_zero", rdata[0], 32'h0);
        end

        access(0, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF);
        access(0, 1'b0, 32'h4, 4'h0, 32'h0);
        chk("rd_deadbeef", rdata[0], 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("rdvalid_one_cycle", {31'b0, rdv[0]}, 32'd0);
        chk("rdata_hold_idle", rdata[0], 32'hDEADBEEF);

        access(0, 1'b1, 32'h4, 4'b0010, 32'h0000AB00);
        access(0, 1'b0, 32'h4, 4'h0, 32'h0);
        chk("rd_lane1", rdata[0], 32'hDEADABEF);
        access(0, 1'b1, 32'h4, 4'b0000, 32'h12345678);
        access(0, 1'b0, 32'h4, 4'h0, 32'h0);
        chk("rd_be_zero", rdata[0], 32'hDEADABEF);

        access(0, 1'b1, 32'h104, 4'hF, 32'h13579BDF);
        access(0, 1'b0, 32'h004, 4'h0, 32'h0);
        chk("rd_wrapped", rdata[0], 32'h13579BDF);

        random_ops(0, 80);

        // Three-wait instance.
        do_reset(1);
        c0 = cyc;
        access(1, 1'b0, 32'h8, 4'h0, 32'h0);
        chk("n3_read_latency", cyc - c0, 4);
        chk("n3_read_zero", rdata[1], 32'h0);

        c0 = cyc;
        access(1, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5);
        access(1, 1'b1, 32'h24, 4'hF, 32'h5A5A5A5A);
        chk("n3_b2b_cycles", cyc - c0, 8);
        access(1, 1'b0, 32'h20, 4'h0, 32'h0);
        chk("n3_b2b_first", rdata[1], 32'hA5A5A5A5);
        access(1, 1'b0, 32'h24, 4'h0, 32'h0);
        chk("n3_b2b_second", rdata[1], 32'h5A5A5A5A);

        random_ops(1, 40);

        // Reset lands on the edge that would have committed a waiting write.
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h10; be[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk("n3_stall_before_rst", {31'b0, stall[1]}, 32'd0);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("rst_wait_busy", {31'b0, busy[1]}, 32'd1);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        wait_init(1);
        access(1, 1'b0, 32'h10, 4'h0, 32'h0);
        chk("rst_wait_no_commit", rdata[1], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
